// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and channel-order helpers for the 8-channel TDM mux.
package tdm_pkg;

  localparam int unsigned CHANNELS = 8;
  localparam int unsigned SEL_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] first_chan(input bit msb_first);
    return msb_first ? SEL_W'(CHANNELS - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] last_chan(input bit msb_first);
    return msb_first ? '0 : SEL_W'(CHANNELS - 1);
  endfunction

  function automatic logic [SEL_W-1:0] next_chan(input logic [SEL_W-1:0] ch, input bit msb_first);
    return msb_first ? ch - SEL_W'(1) : ch + SEL_W'(1);
  endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Slot counter: flags the final cycle of each SLOT_CYCLES-long channel slot while running.
module tdm_slot_timer #(
  parameter int unsigned SLOT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic slot_last
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign slot_last = run && (cnt_q == LAST);

endmodule

// File: rtl/tdm_mux8.sv
// 8-channel time-division multiplexer: parallel word in over valid/ready, one channel per slot out.
module tdm_mux8
  import tdm_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 1,
  parameter bit          MSB_FIRST   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                ser_data,
  output logic [SEL_W-1:0]    ser_sel,
  output logic                ser_valid,
  output logic                frame_start,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                valid_q, valid_d;
  logic                fs_q, fs_d;
  logic                data_q, data_d;
  logic                busy_q;

  logic accept;
  logic slot_last;
  logic frame_end;

  assign in_ready  = !hold_full_q;
  assign accept    = in_valid && !hold_full_q;
  assign frame_end = slot_last && (sel_q == last_chan(MSB_FIRST));

  tdm_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state_q == SHIFT),
    .restart   (state_q == IDLE),
    .slot_last (slot_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      active_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
      data_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      fs_q        <= fs_d;
      data_q      <= data_d;
      busy_q      <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    fs_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          active_d = in_data;
          sel_d    = first_chan(MSB_FIRST);
          valid_d  = 1'b1;
          fs_d     = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_end) begin
          // Chain the next frame with no gap: held word first, else a word arriving right now.
          if (hold_full_q) begin
            active_d    = hold_q;
            hold_full_d = 1'b0;
            sel_d       = first_chan(MSB_FIRST);
            fs_d        = 1'b1;
          end else if (accept) begin
            active_d = in_data;
            sel_d    = first_chan(MSB_FIRST);
            fs_d     = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            sel_d   = '0;
          end
        end else if (slot_last) begin
          sel_d = next_chan(sel_q, MSB_FIRST);
        end
        if (accept && !frame_end) begin
          hold_d      = in_data;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    data_d = valid_d ? active_d[sel_d] : 1'b0;
  end

  assign ser_data    = data_q;
  assign ser_sel     = sel_q;
  assign ser_valid   = valid_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tdm_mux8.sv
// Bench for tdm_mux8: two configurations share one input stream and are scored against a frame-level model.
module tb_tdm_mux8;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;

  logic       rdy   [2];
  logic       sdat  [2];
  logic [2:0] ssel  [2];
  logic       sval  [2];
  logic       fs    [2];
  logic       bsy   [2];

  int unsigned slot_n [2] = '{1, 2};
  bit          msb    [2] = '{1'b0, 1'b1};

  // Model: up to two accepted words (active, held) and the cycle position inside the current frame.
  int         cnt [2];
  int         pos [2];
  logic [7:0] w0  [2];
  logic [7:0] w1  [2];

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tdm_mux8 #(.SLOT_CYCLES(1), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .ser_data(sdat[0]), .ser_sel(ssel[0]), .ser_valid(sval[0]), .frame_start(fs[0]), .busy(bsy[0])
  );

  tdm_mux8 #(.SLOT_CYCLES(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .ser_data(sdat[1]), .ser_sel(ssel[1]), .ser_valid(sval[1]), .frame_start(fs[1]), .busy(bsy[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0;
      pos[i] = 0;
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ser_data[%0d]", i), 32'(sdat[i]), 32'd0);
      check($sformatf("rst_ser_sel[%0d]", i), 32'(ssel[i]), 32'd0);
      check($sformatf("rst_ser_valid[%0d]", i), 32'(sval[i]), 32'd0);
      check($sformatf("rst_frame_start[%0d]", i), 32'(fs[i]), 32'd0);
      check($sformatf("rst_busy[%0d]", i), 32'(bsy[i]), 32'd0);
      check($sformatf("rst_in_ready[%0d]", i), 32'(rdy[i]), 32'd1);
    end
  endtask

  task automatic check_outputs(input int i);
    bit ev;
    int idx;
    int sel;
    ev  = (cnt[i] > 0);
    idx = pos[i] / int'(slot_n[i]);
    sel = msb[i] ? 7 - idx : idx;
    check($sformatf("ser_valid[%0d]", i), 32'(sval[i]), 32'(ev));
    check($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(ev));
    check($sformatf("frame_start[%0d]", i), 32'(fs[i]), 32'(ev && pos[i] == 0));
    if (ev) begin
      check($sformatf("ser_sel[%0d]", i), 32'(ssel[i]), 32'(sel));
      check($sformatf("ser_data[%0d]", i), 32'(sdat[i]), 32'(w0[i][sel]));
    end
  endtask

  // One clock: check readiness, advance the model across the edge, then check registered outputs.
  task automatic step();
    bit acc [2];
    for (int i = 0; i < 2; i++) begin
      check($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(cnt[i] < 2));
      acc[i] = in_valid && (cnt[i] < 2);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (cnt[i] > 0) begin
        pos[i]++;
        if (pos[i] == 8 * int'(slot_n[i])) begin
          w0[i] = w1[i];
          cnt[i]--;
          pos[i] = 0;
        end
      end
      if (acc[i]) begin
        if (cnt[i] == 0) w0[i] = in_data;
        else             w1[i] = in_data;
        cnt[i]++;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_data = 8'($urandom);
      step();
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    #2 rst_n = 1'b1;

    idle(20);

    send(8'hA5);
    idle(20);

    send(8'h81);
    idle(20);

    send(8'hF0);
    idle(1);
    send(8'h0F);
    idle(40);

    send(8'h01);
    idle(7);
    send(8'h02);
    idle(40);

    // Reset mid-frame of the fast instance (sel 3) with its hold register full.
    send(8'h3C);
    send(8'hC3);
    idle(2);
    check("pre_reset_sel[0]", 32'(ssel[0]), 32'd3);
    check("pre_reset_hold[0]", 32'(rdy[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    #2 rst_n = 1'b1;
    idle(25);

    for (int r = 0; r < 900; r++) begin
      if ($urandom_range(0, 15) == 0) begin
        idle(int'($urandom_range(1, 30)));
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        step();
      end
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
